// File: rtl/mmio_bus_arbiter_if.sv
// mmio_bus_arbiter_if
//   Bundle of all bus-side signals around mmio_bus_arbiter: the two master
//   request/acknowledge channels (m0 = CPU, m1 = DMA/debug) and the single
//   downstream MMIO strobe bus.
//   Modports:
//     slave  - arbiter view: master commands and mmio_rd_data in,
//              acks, per-master read data and mmio_* strobes out.
//     master - environment view (masters + slot controller), the mirror image.
interface mmio_bus_arbiter_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
);
    logic              m0_req, m0_wr, m0_rd, m0_ack;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wr_data, m0_rd_data;
    logic              m1_req, m1_wr, m1_rd, m1_ack;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wr_data, m1_rd_data;
    logic              mmio_cs, mmio_wr, mmio_rd;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DATA_W-1:0] mmio_wr_data, mmio_rd_data;

    modport slave (
        input  m0_req, m0_wr, m0_rd, m0_addr, m0_wr_data,
        input  m1_req, m1_wr, m1_rd, m1_addr, m1_wr_data,
        input  mmio_rd_data,
        output m0_ack, m0_rd_data, m1_ack, m1_rd_data,
        output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
    );

    modport master (
        output m0_req, m0_wr, m0_rd, m0_addr, m0_wr_data,
        output m1_req, m1_wr, m1_rd, m1_addr, m1_wr_data,
        output mmio_rd_data,
        input  m0_ack, m0_rd_data, m1_ack, m1_rd_data,
        input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
    );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter
//   Shares the FPRO MMIO bus between two masters. One held request per master
//   is granted (round-robin on conflict), latched, issued as a single
//   registered strobe cycle, read data is captured RD_LAT cycles after the
//   strobe, and a one-cycle ack goes back to the owner.
//   Ports:
//     clk    - system clock, all state on rising edge
//     reset  - synchronous, active-low
//     bus    - mmio_bus_arbiter_if.slave (master channels + MMIO bus)
//   Parameters: ADDR_W, DATA_W, RD_LAT (0..3, strobe-to-data latency).
//   Build option: define MMIO_ARB_FIXED_PRIO_EN for fixed m0 priority
//   instead of round-robin.
//   Every output is a flop; nothing from bus inputs reaches an output
//   combinationally.
module mmio_bus_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input logic               clk,
    input logic               reset,
    mmio_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [1:0] CNT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;         // 0 = m0, 1 = m1
    logic              cmd_wr_q, cmd_wr_d;
    logic              cmd_rd_q, cmd_rd_d;       // already cleared when wr is set
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic              cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              grant1;
    logic              capture;
`ifndef MMIO_ARB_FIXED_PRIO_EN
    logic              last_q, last_d;           // owner of the most recent grant
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_rd_d    = cmd_rd_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cnt_d       = cnt_q;
        rd0_d       = rd0_q;
        rd1_d       = rd1_q;
        capture     = 1'b0;
`ifdef MMIO_ARB_FIXED_PRIO_EN
        grant1      = bus.m1_req & ~bus.m0_req;
`else
        last_d      = last_q;
        // m1 wins when alone, or on conflict when m0 held the last grant
        grant1      = bus.m1_req & (~bus.m0_req | ~last_q);
`endif

        case (state_q)
            IDLE: begin
                if (bus.m0_req | bus.m1_req) begin
                    owner_d     = grant1;
                    // wr and rd together decode as a plain write
                    cmd_wr_d    = grant1 ? bus.m1_wr : bus.m0_wr;
                    cmd_rd_d    = grant1 ? (bus.m1_rd & ~bus.m1_wr)
                                         : (bus.m0_rd & ~bus.m0_wr);
                    cmd_addr_d  = grant1 ? bus.m1_addr : bus.m0_addr;
                    cmd_wdata_d = grant1 ? bus.m1_wr_data : bus.m0_wr_data;
`ifndef MMIO_ARB_FIXED_PRIO_EN
                    last_d      = grant1;
`endif
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (!cmd_rd_q) begin
                    state_d = ACK;
                end else if (RD_LAT == 0) begin
                    capture = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    capture = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (capture) begin
            if (owner_q) rd1_d = bus.mmio_rd_data;
            else         rd0_d = bus.mmio_rd_data;
        end

        // Strobes and acks are decoded one cycle early so they leave on flops.
        cs_d   = (state_d == ISSUE) & (cmd_wr_d | cmd_rd_d);
        wr_d   = (state_d == ISSUE) & cmd_wr_d;
        rd_d   = (state_d == ISSUE) & cmd_rd_d;
        ack0_d = (state_d == ACK) & ~owner_d;
        ack1_d = (state_d == ACK) &  owner_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_rd_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cnt_q       <= 2'd0;
            rd0_q       <= '0;
            rd1_q       <= '0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
`ifndef MMIO_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;   // m0 takes the first conflict
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cnt_q       <= cnt_d;
            rd0_q       <= rd0_d;
            rd1_q       <= rd1_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
`ifndef MMIO_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.mmio_cs      = cs_q;
    assign bus.mmio_wr      = wr_q;
    assign bus.mmio_rd      = rd_q;
    assign bus.mmio_addr    = cmd_addr_q;
    assign bus.mmio_wr_data = cmd_wdata_q;
    assign bus.m0_ack       = ack0_q;
    assign bus.m1_ack       = ack1_q;
    assign bus.m0_rd_data   = rd0_q;
    assign bus.m1_rd_data   = rd1_q;
endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for mmio_bus_arbiter. Four copies run side by side with RD_LAT = 0..3
// on identical stimulus; copy MAIN (RD_LAT = 1) is the one checked except in
// the latency sweep. The slot model returns a value that changes every cycle.
module tb_mmio_bus_arbiter;
    localparam int AW   = 21;
    localparam int DW   = 32;
    localparam int NL   = 4;
    localparam int MAIN = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic logic [31:0] pat(input logic [31:0] c);
        return (c * 32'h9E3779B1) ^ 32'hC3A50F00;
    endfunction

    logic          force_en = 1'b0;
    logic [DW-1:0] force_val = '0;
    logic [DW-1:0] slot_rd;
    assign slot_rd = force_en ? force_val : pat(cyc);

    logic          m0_req, m0_wr, m0_rd, m1_req, m1_wr, m1_rd;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wd, m1_wd;

    logic [NL-1:0] o_ack0, o_ack1, o_cs, o_wr, o_rd;
    logic [AW-1:0] o_addr [NL];
    logic [DW-1:0] o_wd [NL];
    logic [DW-1:0] o_rd0 [NL];
    logic [DW-1:0] o_rd1 [NL];

    int n_chk  = 0;
    int n_pass = 0;

    for (genvar g = 0; g < NL; g++) begin : g_lat
        mmio_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        assign bus.m0_req       = m0_req;
        assign bus.m0_wr        = m0_wr;
        assign bus.m0_rd        = m0_rd;
        assign bus.m0_addr      = m0_addr;
        assign bus.m0_wr_data   = m0_wd;
        assign bus.m1_req       = m1_req;
        assign bus.m1_wr        = m1_wr;
        assign bus.m1_rd        = m1_rd;
        assign bus.m1_addr      = m1_addr;
        assign bus.m1_wr_data   = m1_wd;
        assign bus.mmio_rd_data = slot_rd;

        mmio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(g)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );

        assign o_ack0[g] = bus.m0_ack;
        assign o_ack1[g] = bus.m1_ack;
        assign o_cs[g]   = bus.mmio_cs;
        assign o_wr[g]   = bus.mmio_wr;
        assign o_rd[g]   = bus.mmio_rd;
        assign o_addr[g] = bus.mmio_addr;
        assign o_wd[g]   = bus.mmio_wr_data;
        assign o_rd0[g]  = bus.m0_rd_data;
        assign o_rd1[g]  = bus.m1_rd_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        m0_req = 0; m0_wr = 0; m0_rd = 0; m0_addr = '0; m0_wd = '0;
        m1_req = 0; m1_wr = 0; m1_rd = 0; m1_addr = '0; m1_wd = '0;
    endtask

    task automatic pulse_reset();
        idle_masters();
        step(); reset = 0;
        step(); step(); reset = 1;
    endtask

    task automatic test_reset();
        reset = 0;
        idle_masters();
        step(); step();
        @(negedge clk);
        for (int i = 0; i < NL; i++) begin
            n_chk++; if (o_ack0[i] !== 1'b0) $display("FAIL reset_ack0[%0d] got %b exp 0", i, o_ack0[i]); else n_pass++;
            n_chk++; if (o_ack1[i] !== 1'b0) $display("FAIL reset_ack1[%0d] got %b exp 0", i, o_ack1[i]); else n_pass++;
            n_chk++; if (o_cs[i] !== 1'b0) $display("FAIL reset_cs[%0d] got %b exp 0", i, o_cs[i]); else n_pass++;
            n_chk++; if (o_wr[i] !== 1'b0) $display("FAIL reset_wr[%0d] got %b exp 0", i, o_wr[i]); else n_pass++;
            n_chk++; if (o_rd[i] !== 1'b0) $display("FAIL reset_rd[%0d] got %b exp 0", i, o_rd[i]); else n_pass++;
            n_chk++; if (o_addr[i] !== '0) $display("FAIL reset_addr[%0d] got %h exp 0", i, o_addr[i]); else n_pass++;
            n_chk++; if (o_wd[i] !== '0) $display("FAIL reset_wdata[%0d] got %h exp 0", i, o_wd[i]); else n_pass++;
            n_chk++; if (o_rd0[i] !== '0) $display("FAIL reset_rd0[%0d] got %h exp 0", i, o_rd0[i]); else n_pass++;
            n_chk++; if (o_rd1[i] !== '0) $display("FAIL reset_rd1[%0d] got %h exp 0", i, o_rd1[i]); else n_pass++;
        end
        step(); reset = 1;
    endtask

    task automatic test_single_write();
        step();
        m0_req = 1; m0_wr = 1; m0_rd = 0; m0_addr = 21'h000C4; m0_wd = 32'hDEADBEEF;
        for (int k = 1; k <= 5; k++) begin
            step();
            @(negedge clk);
            n_chk++; if (o_cs[MAIN] !== (k == 1)) $display("FAIL wr_cs k=%0d got %b exp %b", k, o_cs[MAIN], k == 1); else n_pass++;
            n_chk++; if (o_wr[MAIN] !== (k == 1)) $display("FAIL wr_wr k=%0d got %b exp %b", k, o_wr[MAIN], k == 1); else n_pass++;
            n_chk++; if (o_rd[MAIN] !== 1'b0) $display("FAIL wr_rd k=%0d got %b exp 0", k, o_rd[MAIN]); else n_pass++;
            n_chk++; if (o_ack0[MAIN] !== (k == 2)) $display("FAIL wr_ack0 k=%0d got %b exp %b", k, o_ack0[MAIN], k == 2); else n_pass++;
            n_chk++; if (o_ack1[MAIN] !== 1'b0) $display("FAIL wr_ack1 k=%0d got %b exp 0", k, o_ack1[MAIN]); else n_pass++;
            if (k == 1 || k == 5) begin
                n_chk++; if (o_addr[MAIN] !== 21'h000C4) $display("FAIL wr_addr k=%0d got %h exp 000c4", k, o_addr[MAIN]); else n_pass++;
                n_chk++; if (o_wd[MAIN] !== 32'hDEADBEEF) $display("FAIL wr_data k=%0d got %h exp deadbeef", k, o_wd[MAIN]); else n_pass++;
            end
            if (k == 2) idle_masters();
        end
    endtask

    task automatic test_single_read();
        step();
        m1_req = 1; m1_rd = 1; m1_wr = 0; m1_addr = 21'h1A2B0;
        force_val = 32'h12345678;
        for (int k = 1; k <= 6; k++) begin
            step();
            force_en = (k == 2);
            @(negedge clk);
            n_chk++; if (o_cs[MAIN] !== (k == 1)) $display("FAIL rd_cs k=%0d got %b exp %b", k, o_cs[MAIN], k == 1); else n_pass++;
            n_chk++; if (o_rd[MAIN] !== (k == 1)) $display("FAIL rd_rd k=%0d got %b exp %b", k, o_rd[MAIN], k == 1); else n_pass++;
            n_chk++; if (o_ack1[MAIN] !== (k == 3)) $display("FAIL rd_ack1 k=%0d got %b exp %b", k, o_ack1[MAIN], k == 3); else n_pass++;
            n_chk++; if (o_ack0[MAIN] !== 1'b0) $display("FAIL rd_ack0 k=%0d got %b exp 0", k, o_ack0[MAIN]); else n_pass++;
            n_chk++; if (o_rd0[MAIN] !== '0) $display("FAIL rd_rd0 k=%0d got %h exp 0", k, o_rd0[MAIN]); else n_pass++;
            if (k >= 3) begin
                n_chk++; if (o_rd1[MAIN] !== 32'h12345678) $display("FAIL rd_rd1 k=%0d got %h exp 12345678", k, o_rd1[MAIN]); else n_pass++;
            end
            if (k == 3) idle_masters();
        end
        force_en = 0;
    endtask

    task automatic test_noop();
        step();
        m0_req = 1; m0_wr = 0; m0_rd = 0; m0_addr = 21'h00100;
        for (int k = 1; k <= 4; k++) begin
            step();
            @(negedge clk);
            n_chk++; if (o_cs[MAIN] !== 1'b0) $display("FAIL noop_cs k=%0d got %b exp 0", k, o_cs[MAIN]); else n_pass++;
            n_chk++; if (o_ack0[MAIN] !== (k == 2)) $display("FAIL noop_ack0 k=%0d got %b exp %b", k, o_ack0[MAIN], k == 2); else n_pass++;
            n_chk++; if (o_rd0[MAIN] !== '0) $display("FAIL noop_rd0 k=%0d got %h exp 0", k, o_rd0[MAIN]); else n_pass++;
            if (k == 2) idle_masters();
        end
        step();
        m1_req = 1; m1_wr = 1; m1_rd = 1; m1_addr = 21'h0ABCD; m1_wd = 32'hCAFEF00D;
        for (int k = 1; k <= 4; k++) begin
            step();
            @(negedge clk);
            n_chk++; if (o_cs[MAIN] !== (k == 1)) $display("FAIL both_cs k=%0d got %b exp %b", k, o_cs[MAIN], k == 1); else n_pass++;
            n_chk++; if (o_wr[MAIN] !== (k == 1)) $display("FAIL both_wr k=%0d got %b exp %b", k, o_wr[MAIN], k == 1); else n_pass++;
            n_chk++; if (o_rd[MAIN] !== 1'b0) $display("FAIL both_rd k=%0d got %b exp 0", k, o_rd[MAIN]); else n_pass++;
            n_chk++; if (o_ack1[MAIN] !== (k == 2)) $display("FAIL both_ack1 k=%0d got %b exp %b", k, o_ack1[MAIN], k == 2); else n_pass++;
            n_chk++; if (o_rd1[MAIN] !== 32'h12345678) $display("FAIL both_rd1 k=%0d got %h exp 12345678", k, o_rd1[MAIN]); else n_pass++;
            if (k == 1) begin
                n_chk++; if (o_wd[MAIN] !== 32'hCAFEF00D) $display("FAIL both_data got %h exp cafef00d", o_wd[MAIN]); else n_pass++;
            end
            if (k == 2) idle_masters();
        end
    endtask

    task automatic test_rr_conflict();
        int order [5];
        int n;
        int exp_m;
        n = 0;
        pulse_reset();
        step();
        m0_req = 1; m0_rd = 1; m0_wr = 0; m0_addr = 21'h00010;
        m1_req = 1; m1_rd = 1; m1_wr = 0; m1_addr = 21'h00020;
        for (int c = 0; c < 60 && n < 5; c++) begin
            step();
            @(negedge clk);
            if (o_ack0[MAIN]) begin order[n] = 0; n++; end
            else if (o_ack1[MAIN]) begin order[n] = 1; n++; end
            if (n == 4) m0_req = 0;
        end
        n_chk++; if (n != 5) $display("FAIL rr_timeout grants got %0d exp 5", n); else n_pass++;
        for (int i = 0; i < n; i++) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
            exp_m = (i == 4) ? 1 : 0;
`else
            exp_m = (i == 4) ? 1 : (i % 2);
`endif
            n_chk++; if (order[i] != exp_m) $display("FAIL rr_grant%0d got m%0d exp m%0d", i, order[i], exp_m); else n_pass++;
        end
        idle_masters();
        repeat (10) step();
    endtask

    task automatic test_lat_sweep();
        logic [31:0] c1;
        c1 = '0;
        step();
        m0_req = 1; m0_rd = 1; m0_wr = 0; m0_addr = AW'($urandom);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) c1 = cyc;
            @(negedge clk);
            for (int i = 0; i < NL; i++) begin
                n_chk++; if (o_ack0[i] !== (k == 2 + i)) $display("FAIL lat%0d_ack0 k=%0d got %b exp %b", i, k, o_ack0[i], k == 2 + i); else n_pass++;
                if (k == 2 + i) begin
                    n_chk++; if (o_rd0[i] !== pat(c1 + 32'(i))) $display("FAIL lat%0d_data got %h exp %h", i, o_rd0[i], pat(c1 + 32'(i))); else n_pass++;
                end
            end
            if (k == 1) idle_masters();   // early drop must not cancel
        end
    endtask

    task automatic test_reset_wait();
        step();
        m0_req = 1; m0_rd = 1; m0_wr = 0; m0_addr = 21'h00444;
        step();
        @(negedge clk);
        n_chk++; if (o_rd[MAIN] !== 1'b1) $display("FAIL rw_strobe got %b exp 1", o_rd[MAIN]); else n_pass++;
        step();
        reset = 0;
        idle_masters();
        @(negedge clk);
        n_chk++; if (o_ack0[MAIN] !== 1'b0) $display("FAIL rw_wait_ack0 got %b exp 0", o_ack0[MAIN]); else n_pass++;
        step();
        @(negedge clk);
        n_chk++; if (o_ack0[MAIN] !== 1'b0) $display("FAIL rw_ack0 got %b exp 0", o_ack0[MAIN]); else n_pass++;
        n_chk++; if (o_ack1[MAIN] !== 1'b0) $display("FAIL rw_ack1 got %b exp 0", o_ack1[MAIN]); else n_pass++;
        n_chk++; if ({o_cs[MAIN], o_wr[MAIN], o_rd[MAIN]} !== 3'b000) $display("FAIL rw_strobes got %b exp 000", {o_cs[MAIN], o_wr[MAIN], o_rd[MAIN]}); else n_pass++;
        n_chk++; if (o_addr[MAIN] !== '0) $display("FAIL rw_addr got %h exp 0", o_addr[MAIN]); else n_pass++;
        n_chk++; if (o_rd0[MAIN] !== '0) $display("FAIL rw_rd0 got %h exp 0", o_rd0[MAIN]); else n_pass++;
        n_chk++; if (o_rd1[MAIN] !== '0) $display("FAIL rw_rd1 got %h exp 0", o_rd1[MAIN]); else n_pass++;
        reset = 1;
        step();
        m0_req = 1; m0_wr = 1; m0_addr = 21'h00008; m0_wd = 32'h00000A0A;
        m1_req = 1; m1_wr = 1; m1_addr = 21'h0000C; m1_wd = 32'h00000B0B;
        for (int k = 1; k <= 6; k++) begin
            step();
            @(negedge clk);
            n_chk++; if (o_ack0[MAIN] !== (k == 2)) $display("FAIL rw_first_ack0 k=%0d got %b exp %b", k, o_ack0[MAIN], k == 2); else n_pass++;
            n_chk++; if (o_ack1[MAIN] !== (k == 5)) $display("FAIL rw_first_ack1 k=%0d got %b exp %b", k, o_ack1[MAIN], k == 5); else n_pass++;
            if (k == 2) m0_req = 0;
            if (k == 5) m1_req = 0;
        end
        idle_masters();
    endtask

    // Transaction-level model: grant order from the arbitration rule, then
    // strobe/ack cycles from the fixed latencies, read data from the slot
    // pattern one cycle after the strobe.
    task automatic test_random();
        logic [DW-1:0] mrd [2];
        int last_m;
        pulse_reset();
        mrd[0] = '0; mrd[1] = '0; last_m = 1;
        for (int r = 0; r < 40; r++) begin
            logic          w [2];
            logic          rr [2];
            logic [AW-1:0] ad [2];
            logic [DW-1:0] dt [2];
            logic [31:0]   scyc [2];
            int            own [2];
            int            s [2];
            int            a [2];
            int            mask, ntx, klast;
            mask = int'($urandom_range(1, 3));
            for (int j = 0; j < 2; j++) begin
                w[j] = 1'($urandom); rr[j] = 1'($urandom);
                ad[j] = AW'($urandom); dt[j] = $urandom;
                scyc[j] = '0;
            end
            if (mask == 3) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
                own[0] = 0;
`else
                own[0] = (last_m == 1) ? 0 : 1;
`endif
                own[1] = 1 - own[0];
                ntx = 2;
            end else begin
                own[0] = (mask == 1) ? 0 : 1;
                own[1] = 1 - own[0];
                ntx = 1;
            end
            last_m = own[ntx-1];
            s[0] = 1;
            a[0] = 2 + ((rr[own[0]] & ~w[own[0]]) ? 1 : 0);
            s[1] = a[0] + 2;
            a[1] = s[1] + 1 + ((rr[own[1]] & ~w[own[1]]) ? 1 : 0);
            klast = a[ntx-1] + 1;

            step();
            m0_req = (mask & 1) != 0; m0_wr = w[0]; m0_rd = rr[0]; m0_addr = ad[0]; m0_wd = dt[0];
            m1_req = (mask & 2) != 0; m1_wr = w[1]; m1_rd = rr[1]; m1_addr = ad[1]; m1_wd = dt[1];
            for (int k = 1; k <= klast; k++) begin
                logic ecs, ea0, ea1;
                int   t;
                step();
                for (int x = 0; x < ntx; x++) if (k == s[x]) scyc[x] = cyc;
                @(negedge clk);
                ecs = 0; ea0 = 0; ea1 = 0; t = -1;
                for (int x = 0; x < ntx; x++) begin
                    if (k == s[x] && (w[own[x]] | rr[own[x]])) begin ecs = 1; t = own[x]; end
                    if (k == a[x]) begin
                        if (own[x] == 0) ea0 = 1; else ea1 = 1;
                        if (rr[own[x]] & ~w[own[x]]) mrd[own[x]] = pat(scyc[x] + 32'd1);
                    end
                end
                n_chk++; if (o_cs[MAIN] !== ecs) $display("FAIL rnd%0d_cs k=%0d got %b exp %b", r, k, o_cs[MAIN], ecs); else n_pass++;
                n_chk++; if (o_ack0[MAIN] !== ea0) $display("FAIL rnd%0d_ack0 k=%0d got %b exp %b", r, k, o_ack0[MAIN], ea0); else n_pass++;
                n_chk++; if (o_ack1[MAIN] !== ea1) $display("FAIL rnd%0d_ack1 k=%0d got %b exp %b", r, k, o_ack1[MAIN], ea1); else n_pass++;
                if (t >= 0) begin
                    n_chk++; if (o_wr[MAIN] !== w[t]) $display("FAIL rnd%0d_wr got %b exp %b", r, o_wr[MAIN], w[t]); else n_pass++;
                    n_chk++; if (o_rd[MAIN] !== (rr[t] & ~w[t])) $display("FAIL rnd%0d_rd got %b exp %b", r, o_rd[MAIN], rr[t] & ~w[t]); else n_pass++;
                    n_chk++; if (o_addr[MAIN] !== ad[t]) $display("FAIL rnd%0d_addr got %h exp %h", r, o_addr[MAIN], ad[t]); else n_pass++;
                    n_chk++; if (o_wd[MAIN] !== dt[t]) $display("FAIL rnd%0d_data got %h exp %h", r, o_wd[MAIN], dt[t]); else n_pass++;
                end
                if (ea0 | ea1) begin
                    n_chk++; if (o_rd0[MAIN] !== mrd[0]) $display("FAIL rnd%0d_rd0 got %h exp %h", r, o_rd0[MAIN], mrd[0]); else n_pass++;
                    n_chk++; if (o_rd1[MAIN] !== mrd[1]) $display("FAIL rnd%0d_rd1 got %h exp %h", r, o_rd1[MAIN], mrd[1]); else n_pass++;
                end
                if (ea0) m0_req = 0;
                if (ea1) m1_req = 0;
            end
        end
        idle_masters();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_noop();
        test_rr_conflict();
        test_lat_sweep();
        test_reset_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
